pdm_cic_capture: RTL and testbench
==================================

Name: pdm_cic_capture

Overview:
- Upstream capture stage for the delay buffer.
- Consumes the synchronized 1-bit PDM microphone stream on the 3.072 MHz mic clock and decimates it with a 3rd-order CIC filter (R=64) to 48 kHz, 16-bit signed PCM.
- Writes each PCM sample into the dual-port delay-buffer BRAM (port A) through a circular write-address sequencer with selectable buffer length.
- The AudioOutput reader on port B consumes these samples.

Parameters:
- DECIM, 64, decimation ratio R (power of two; fixed CIC order 3, differential delay 1).
- ADDR_W, 16, BRAM address width; full buffer depth = 2^ADDR_W.
- ACC_W, 19, integrator/comb width = 3*log2(DECIM)+1.

Ports:
- clk  in  1  mic clock (3.072 MHz); all logic on rising edge.
- sysreset_n  in  1  asynchronous, active-low reset.
- pdm_in  in  1  synchronized PDM bit; already synchronized upstream, no internal synchronizer.
- enable  in  1  capture enable; low inhibits writes.
- len_sel  in  2  buffer length select: limit = 2^(ADDR_W - len_sel).
- write_enable  out  1  BRAM port-A write strobe, one clk wide.
- write_address  out  ADDR_W  BRAM port-A address.
- write_data  out  16  signed PCM sample.
- wrap_pulse  out  1  one-clk pulse when the write at address limit-1 occurs.

Behaviour:
- Reset (async assert, sync deassert): all integrators, combs, counters = 0; write_enable=0, write_address=0, write_data=16'h0000, wrap_pulse=0; warm-up count = 0.
- Integrators: 3 cascaded, ACC_W bits, modulo arithmetic (wrap is intentional). Input term = pdm_in (0 or 1). Update every clk regardless of enable.
- Decimation counter dcnt: 0..DECIM-1, +1 per clk, wraps to 0. Boundary cycle = dcnt==DECIM-1. At the boundary, register integrator-3 output into the comb stage.
- Combs: 3 cascaded differences (y - y_prev), ACC_W modulo. Computed and registered the cycle after the boundary as raw value y.
- Raw range: y in [0, 262144].
- PCM mapping: s = (y - 131072) >>> 2, saturated to [-32768, 32767]. So y=262144 gives 32767, y=0 gives -32768, y=131072 gives 0.
- Write timing: write_enable high for exactly one clk, 2 clks after the boundary cycle. write_data and write_address are valid in that same cycle. write_data holds its value between writes.
- Warm-up: after reset, or after enable returns high, the first 3 decimated samples are discarded with no write. The warm-up counter saturates at 3. enable low clears the warm-up counter.
- enable low:
  - No writes.
  - write_address is held.
  - Filter keeps running.
  - If enable falls between the boundary and the write cycle, that write is suppressed.
- Address sequencing:
  - After each write, write_address increments.
  - If write_address >= limit-1 at the write, the next address = 0 and wrap_pulse is asserted coincident with that write.
  - If len_sel changes so that the held address >= new limit, the next write goes to address 0 and does not pulse wrap.
- len_sel is sampled only at write cycles.
- Throughput: one sample per DECIM clks, no backpressure. BRAM port A always accepts.

Test Plan:
- Reset, enable=1, len_sel=0, pdm_in constant 1 -> no write before the 4th boundary. First write at address 0, 2 clks after the 4th boundary (clk 257 after reset release). All writes have write_data=16'h7FFF, addresses 0,1,2,..., spaced 64 clks apart.
- pdm_in constant 0 -> every write after warm-up has write_data=16'h8000.
- pdm_in alternating 1,0,1,0 -> every write after warm-up has write_data=16'h0000 exactly.
- len_sel=3 (limit 8192), run 8193 writes -> write 8192 lands at address 8191 with wrap_pulse=1, and write 8193 lands at address 0. Then switch len_sel=0 -> addresses continue 1,2,... with no wrap until 65535.
- Mid-run: address 100, drop enable for 500 clks, raise it -> 3 samples discarded, next write at address 100. Separately, assert sysreset_n low mid-sample -> outputs 0 immediately (async), and after release the warm-up restarts with first write at address 0.
- Write at address 5000, then set len_sel=2 (limit 16384, no effect) and later len_sel=3 at address 9000 -> next write at address 0, wrap_pulse=0.

Source files
------------

// File: rtl/pdm_cic_capture_if.sv
// PDM capture bus: PDM/control inputs toward the capture stage, BRAM port-A writes out of it.
interface pdm_cic_capture_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              pdm_in;
    logic              enable;
    logic [1:0]        len_sel;
    logic              write_enable;
    logic [ADDR_W-1:0] write_address;
    logic [15:0]       write_data;
    logic              wrap_pulse;

    // master: the capture stage; slave: the source/BRAM side
    modport master (
        input  pdm_in, enable, len_sel,
        output write_enable, write_address, write_data, wrap_pulse
    );

    modport slave (
        output pdm_in, enable, len_sel,
        input  write_enable, write_address, write_data, wrap_pulse
    );
endinterface

// File: rtl/pdm_cic_capture.sv
// 3rd-order CIC decimator (PDM -> 16-bit PCM) feeding a circular BRAM write-address sequencer.
module pdm_cic_capture #(
    parameter int unsigned DECIM  = 64,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned ACC_W  = 19
) (
    input  logic                clk,
    input  logic                sysreset_n,
    pdm_cic_capture_if.master   bus
);

    localparam int unsigned DCNT_W = $clog2(DECIM);
    localparam int unsigned HALF   = 1 << (ACC_W - 2);
    localparam int unsigned SHIFT  = ACC_W - 17;
    localparam logic [1:0]  WARM_N = 2'd3;
    localparam logic signed [ACC_W:0] PCM_MAX = (ACC_W + 1)'(32'sd32767);
    localparam logic signed [ACC_W:0] PCM_MIN = (ACC_W + 1)'(-32'sd32768);

    logic [ACC_W-1:0]  integ1, integ2, integ3;
    logic [ACC_W-1:0]  samp, dly1, dly2, dly3;
    logic [DCNT_W-1:0] dcnt;
    logic              comb_go;
    logic [1:0]        warm;

    logic              boundary_c;
    logic [ACC_W-1:0]  c1_c, c2_c, c3_c;
    logic signed [ACC_W:0] centered_c, scaled_c;
    logic [15:0]       pcm_c;
    logic [ADDR_W-1:0] lim_m1_c, eff_addr_c;
    logic              write_go_c;

    // comb chain, PCM mapping and address limit for the cycle after a boundary
    always_comb begin
        boundary_c = (dcnt == DCNT_W'(DECIM - 1));
        c1_c       = samp - dly1;
        c2_c       = c1_c - dly2;
        c3_c       = c2_c - dly3;
        centered_c = $signed({1'b0, c3_c}) - $signed((ACC_W + 1)'(HALF));
        scaled_c   = centered_c >>> SHIFT;
        if (scaled_c > PCM_MAX) begin
            pcm_c = 16'h7FFF;
        end else if (scaled_c < PCM_MIN) begin
            pcm_c = 16'h8000;
        end else begin
            pcm_c = scaled_c[15:0];
        end
        lim_m1_c   = {ADDR_W{1'b1}} >> bus.len_sel;
        eff_addr_c = (bus.write_address > lim_m1_c) ? '0 : bus.write_address;
        write_go_c = comb_go && bus.enable && (warm == WARM_N);
    end

    always_ff @(posedge clk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            integ1            <= '0;
            integ2            <= '0;
            integ3            <= '0;
            samp              <= '0;
            dly1              <= '0;
            dly2              <= '0;
            dly3              <= '0;
            dcnt              <= '0;
            comb_go           <= 1'b0;
            warm              <= '0;
            bus.write_enable  <= 1'b0;
            bus.write_address <= '0;
            bus.write_data    <= 16'h0000;
            bus.wrap_pulse    <= 1'b0;
        end else begin
            // integrators free-run modulo 2^ACC_W regardless of enable
            integ1  <= integ1 + ACC_W'(bus.pdm_in);
            integ2  <= integ2 + integ1;
            integ3  <= integ3 + integ2;
            dcnt    <= dcnt + DCNT_W'(1);
            comb_go <= boundary_c;
            if (boundary_c) begin
                samp <= integ3;
            end
            if (comb_go) begin
                dly1 <= samp;
                dly2 <= c1_c;
                dly3 <= c2_c;
            end

            // first three samples after reset or enable rise only prime the combs
            if (!bus.enable) begin
                warm <= '0;
            end else if (comb_go && (warm != WARM_N)) begin
                warm <= warm + 2'd1;
            end

            bus.write_enable <= 1'b0;
            bus.wrap_pulse   <= 1'b0;
            if (write_go_c) begin
                bus.write_enable  <= 1'b1;
                bus.write_address <= eff_addr_c;
                bus.wrap_pulse    <= (eff_addr_c == lim_m1_c);
                bus.write_data    <= pcm_c;
            end else if (bus.write_enable) begin
                bus.write_address <= bus.wrap_pulse ? '0 : bus.write_address + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_capture.sv
// Randomized bench for pdm_cic_capture against an FIR-form CIC reference model.
module tb_pdm_cic_capture;

    localparam int unsigned AW = 8;
    localparam int R  = 64;

    logic clk = 1'b0;
    logic sysreset_n = 1'b1;
    always #5 clk = ~clk;

    pdm_cic_capture_if #(.ADDR_W(AW)) bus ();

    pdm_cic_capture #(.DECIM(64), .ADDR_W(AW), .ACC_W(19)) dut (
        .clk        (clk),
        .sysreset_n (sysreset_n),
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // stimulus source: 0 const0, 1 const1, 2 alternating, 3 random bits, 4 random density
    int mode = 1;
    int dens = 50;
    bit alt  = 1'b0;
    initial begin
        bus.pdm_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: bus.pdm_in = 1'b0;
                1: bus.pdm_in = 1'b1;
                2: begin alt = ~alt; bus.pdm_in = alt; end
                3: bus.pdm_in = 1'($urandom % 2);
                default: bus.pdm_in = ($urandom_range(99) < dens);
            endcase
        end
    end

    // reference model: integrator kernel C(d-1,2), third difference at stride R
    bit hist[$];

    function automatic longint g3(input longint d);
        return (d >= 1) ? ((d - 1) * (d - 2)) / 2 : 0;
    endfunction

    function automatic longint h(input longint d);
        return g3(d) - 3 * g3(d - R) + 3 * g3(d - 2 * R) - g3(d - 3 * R);
    endfunction

    function automatic longint cic_out(input int b);
        longint y = 0;
        for (int u = (b > 3 * R) ? b - 3 * R : 0; u < b; u++) begin
            if (hist[u]) y += h(longint'(b - u));
        end
        return y;
    endfunction

    function automatic logic [15:0] pcm(input longint y);
        longint s = (y - 131072) >>> 2;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    int          t = 0;
    int          m_addr = 0;
    int          m_warm = 0;
    int          lim;
    logic        m_we = 1'b0;
    logic        m_wrap = 1'b0;
    logic [15:0] m_data = 16'h0000;

    always @(negedge clk) begin
        if (!sysreset_n) begin
            t = 0; hist.delete();
            m_we = 1'b0; m_wrap = 1'b0; m_addr = 0; m_data = 16'h0000; m_warm = 0;
        end else begin
            check("m_we", 32'(bus.write_enable), 32'(m_we));
            check("m_wrap", 32'(bus.wrap_pulse), 32'(m_wrap));
            if (m_we || (t % 16) == 0) begin
                check("m_addr", 32'(bus.write_address), 32'(m_addr));
                check("m_data", 32'(bus.write_data), 32'(m_data));
            end
            hist.push_back(bus.pdm_in);
            if (m_we) m_addr = m_wrap ? 0 : m_addr + 1;
            m_we = 1'b0;
            m_wrap = 1'b0;
            if (!bus.enable) m_warm = 0;
            if (t >= R && (t % R) == 0 && bus.enable) begin
                if (m_warm < 3) begin
                    m_warm++;
                end else begin
                    lim = ((1 << AW) >> bus.len_sel) - 1;
                    if (m_addr > lim) m_addr = 0;
                    m_wrap = (m_addr == lim);
                    m_we   = 1'b1;
                    m_data = pcm(cic_out(t - 1));
                end
            end
            t++;
        end
    end

    task automatic wait_write(input string tag, output int cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.write_enable !== 1'b1 && n < 600);
        if (bus.write_enable !== 1'b1) check({tag, "_timeout"}, 32'd0, 32'd1);
        cyc = n - 1;
    endtask

    // from the negedge of a write cycle, move to mid-sample (decimation phase 32)
    task automatic mid();
        @(posedge clk);
        repeat (30) @(posedge clk);
        #1;
    endtask

    int cyc;
    initial begin
        bus.enable  = 1'b1;
        bus.len_sel = 2'd0;
        #1 sysreset_n = 1'b0;
        #1;
        check("rst_we", 32'(bus.write_enable), 32'd0);
        check("rst_addr", 32'(bus.write_address), 32'd0);
        check("rst_data", 32'(bus.write_data), 32'd0);
        check("rst_wrap", 32'(bus.wrap_pulse), 32'd0);
        @(posedge clk); @(posedge clk); #1 sysreset_n = 1'b1;

        wait_write("first", cyc);
        check("first_cyc", 32'(cyc), 32'd257);
        check("first_addr", 32'(bus.write_address), 32'd0);
        check("c1_data", 32'(bus.write_data), 32'h7FFF);
        for (int i = 1; i < 6; i++) begin
            wait_write("c1", cyc);
            check("c1_spacing", 32'(cyc), 32'd63);
            check("c1_addr", 32'(bus.write_address), 32'(i));
            check("c1_data", 32'(bus.write_data), 32'h7FFF);
        end

        mode = 0;
        repeat (4) wait_write("c0s", cyc);
        for (int i = 0; i < 3; i++) begin
            wait_write("c0", cyc);
            check("c0_data", 32'(bus.write_data), 32'h8000);
        end
        mode = 2;
        repeat (4) wait_write("alts", cyc);
        for (int i = 0; i < 3; i++) begin
            wait_write("alt", cyc);
            check("alt_data", 32'(bus.write_data), 32'h0000);
        end

        // wrap at limit 32 starting from address 20
        mode = 3;
        mid();
        bus.len_sel = 2'd3;
        for (int i = 20; i < 32; i++) begin
            wait_write("wrap", cyc);
            check("wrap_addr", 32'(bus.write_address), 32'(i));
            check("wrap_pulse", 32'(bus.wrap_pulse), 32'(i == 31));
        end
        wait_write("wrap0", cyc);
        check("wrap0_addr", 32'(bus.write_address), 32'd0);
        check("wrap0_pulse", 32'(bus.wrap_pulse), 32'd0);
        mid();
        bus.len_sel = 2'd0;
        for (int i = 1; i < 3; i++) begin
            wait_write("full", cyc);
            check("full_addr", 32'(bus.write_address), 32'(i));
            check("full_pulse", 32'(bus.wrap_pulse), 32'd0);
        end

        // enable drop holds the address and restarts warm-up
        mid();
        bus.enable = 1'b0;
        repeat (500) @(posedge clk);
        #1 bus.enable = 1'b1;
        wait_write("en", cyc);
        check("en_resume_cyc", 32'(cyc), 32'd237);
        check("en_addr", 32'(bus.write_address), 32'd3);

        // shrinking below the held address restarts at 0 without a wrap pulse
        mid();
        bus.len_sel = 2'd2;
        for (int i = 4; i <= 40; i++) begin
            wait_write("len2", cyc);
            check("len2_addr", 32'(bus.write_address), 32'(i));
        end
        mid();
        bus.len_sel = 2'd3;
        wait_write("shrink", cyc);
        check("shrink_addr", 32'(bus.write_address), 32'd0);
        check("shrink_pulse", 32'(bus.wrap_pulse), 32'd0);
        wait_write("shrink1", cyc);
        check("shrink1_addr", 32'(bus.write_address), 32'd1);

        // random densities, lengths and enable gaps; model checks every cycle
        mode = 4;
        mid();
        for (int k = 0; k < 200; k++) begin
            dens = $urandom_range(100);
            mode = ($urandom_range(4) == 0) ? 3 : 4;
            if ($urandom_range(3) == 0) bus.len_sel = 2'($urandom_range(3));
            if ($urandom_range(9) == 0) begin
                bus.enable = 1'b0;
                repeat (64 * $urandom_range(1, 4)) @(posedge clk);
                #1 bus.enable = 1'b1;
            end
            repeat (64) @(posedge clk);
            #1;
        end

        // async reset mid-sample
        mode = 1;
        bus.enable = 1'b1;
        repeat (64) @(posedge clk);
        #1 sysreset_n = 1'b0;
        #1;
        check("arst_we", 32'(bus.write_enable), 32'd0);
        check("arst_addr", 32'(bus.write_address), 32'd0);
        check("arst_data", 32'(bus.write_data), 32'd0);
        check("arst_wrap", 32'(bus.wrap_pulse), 32'd0);
        repeat (2) @(posedge clk);
        #1 sysreset_n = 1'b1;
        wait_write("arst_first", cyc);
        check("arst_first_cyc", 32'(cyc), 32'd257);
        check("arst_first_addr", 32'(bus.write_address), 32'd0);
        check("arst_first_data", 32'(bus.write_data), 32'h7FFF);
        wait_write("arst_next", cyc);
        check("arst_next_addr", 32'(bus.write_address), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
